// File: rtl/seg_scan_decoder_if.sv
// seg_scan_decoder_if: scanned seven-segment bus in, decoded score and status out.
interface seg_scan_decoder_if;
  logic [7:0]  seg_in;
  logic [3:0]  sel_in;
  logic [15:0] score;
  logic        score_valid;
  logic        decode_err;
  logic        link_lost;
  logic        blank;
  modport master (output seg_in, sel_in, input score, score_valid, decode_err, link_lost, blank);
  modport slave  (input seg_in, sel_in, output score, score_valid, decode_err, link_lost, blank);
endinterface

// File: rtl/seg_scan_decoder.sv
// seg_scan_decoder: rebuilds a 4-digit BCD score from a multiplexed seven-segment scan,
// publishing only after two identical consecutive frames.
module seg_scan_decoder #(
  parameter int TIMEOUT_CYC = 400_000
) (
  input logic clk,
  input logic rst,
  seg_scan_decoder_if.slave bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);
  typedef enum logic [1:0] {IDLE, ARMED, LOST, BLANK} state_t;
  state_t r_state, w_next;
  logic [7:0]    r_seg_q;
  logic [3:0]    r_sel_q, r_sel_p, r_mask;
  logic [15:0]   r_asm, r_cand, r_score;
  logic          r_score_valid, r_decode_err;
  logic [CW-1:0] r_cnt;
  logic [3:0]    w_digit;
  logic [1:0]    w_idx;
  logic          w_valid, w_sel_ok, w_cap, w_blank, w_to, w_done, w_pub;
  always_comb begin
    w_digit = 4'd0;
    w_valid = 1'b1;
    case (r_seg_q)
      8'hC0: w_digit = 4'd0;
      8'hF9: w_digit = 4'd1;
      8'hA4: w_digit = 4'd2;
      8'hB0: w_digit = 4'd3;
      8'h99: w_digit = 4'd4;
      8'h92: w_digit = 4'd5;
      8'h82: w_digit = 4'd6;
      8'hF8: w_digit = 4'd7;
      8'h80: w_digit = 4'd8;
      8'h90: w_digit = 4'd9;
      default: w_valid = 1'b0;
    endcase
  end
  assign w_idx    = r_sel_q == 4'b0111 ? 2'd0 : r_sel_q == 4'b1011 ? 2'd1 : r_sel_q == 4'b1101 ? 2'd2 : 2'd3;
  assign w_sel_ok = r_sel_q inside {4'b0111, 4'b1011, 4'b1101, 4'b1110};
  assign w_cap    = w_sel_ok && r_sel_q != r_sel_p;
  assign w_blank  = r_sel_q == 4'b0000;
  assign w_to     = r_cnt == CW'(TIMEOUT_CYC);
  assign w_done   = r_mask == 4'hF && !w_blank;
  assign w_pub    = w_done && r_state == ARMED && r_asm == r_cand && r_asm != r_score;
  // A capture always outranks a coincident timeout so the link recovers on the first new digit.
  always_comb begin
    w_next = r_state == BLANK ? IDLE : r_state;
    if (w_done) w_next = ARMED;
    if (w_cap) w_next = (!w_valid || w_next == LOST) ? IDLE : w_next;
    else if (w_to) w_next = LOST;
    if (w_blank) w_next = BLANK;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= IDLE;
      r_seg_q       <= 8'hFF;
      r_sel_q       <= 4'hF;
      r_sel_p       <= 4'hF;
      r_mask        <= 4'h0;
      r_asm         <= 16'h0;
      r_cand        <= 16'h0;
      r_score       <= 16'h0;
      r_score_valid <= 1'b0;
      r_decode_err  <= 1'b0;
      r_cnt         <= '0;
    end else begin
      r_state       <= w_next;
      r_seg_q       <= bus.seg_in;
      r_sel_q       <= bus.sel_in;
      r_sel_p       <= r_sel_q;
      r_score_valid <= w_pub;
      r_decode_err  <= w_cap && !w_valid;
      if (w_blank || (w_to && !w_cap) || (w_cap && !w_valid)) r_mask <= 4'h0;
      else if (w_cap) r_mask <= (w_done ? 4'h0 : r_mask) | (4'b0001 << w_idx);
      else if (w_done) r_mask <= 4'h0;
      if (w_cap && w_valid) r_asm[{w_idx, 2'b00} +: 4] <= w_digit;
      if (w_done) r_cand <= r_asm;
      if (w_pub) r_score <= r_asm;
      if (w_blank || w_cap) r_cnt <= '0;
      else if (!w_to) r_cnt <= r_cnt + 1'b1;
    end
  end
  assign bus.score       = r_score;
  assign bus.score_valid = r_score_valid;
  assign bus.decode_err  = r_decode_err;
  assign bus.link_lost   = r_state == LOST;
  assign bus.blank       = w_blank;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb_seg_scan_decoder: directed scans with a score scoreboard checked by an independent monitor.
module tb_seg_scan_decoder;
  localparam int TO = 200;
  logic clk = 1'b0;
  logic rst = 1'b0;
  seg_scan_decoder_if bus();
  seg_scan_decoder #(.TIMEOUT_CYC(TO)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  int de_cnt = 0;
  int n;
  logic [15:0] exp_q[$];
  logic [7:0] lut [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
  logic [3:0] sel_lut [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask
  task automatic put(input logic [3:0] s, input logic [7:0] g);
    bus.sel_in = s;
    bus.seg_in = g;
  endtask
  task automatic digit(input logic [3:0] s, input logic [7:0] g);
    put(s, g);
    repeat (4) @(negedge clk);
  endtask
  task automatic frame(input logic [15:0] v, input bit bad_tens);
    for (int i = 0; i < 4; i++) digit(sel_lut[i], (bad_tens && i == 1) ? 8'hFF : lut[v[i*4 +: 4]]);
  endtask
  always @(negedge clk) begin
    if (rst && bus.score_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pulse actual=%h required=none", bus.score);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (bus.score !== e) begin
          errors++;
          $display("FAIL score_pub actual=%h required=%h", bus.score, e);
        end
      end
    end
    if (rst && bus.decode_err) de_cnt++;
  end
  initial begin
    put(4'hF, 8'hFF);
    repeat (3) @(negedge clk);
    chk("rst_score", bus.score, 16'h0);
    chk("rst_sv", bus.score_valid, 1'b0);
    chk("rst_de", bus.decode_err, 1'b0);
    chk("rst_ll", bus.link_lost, 1'b0);
    chk("rst_blank", bus.blank, 1'b0);
    rst = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_ll", bus.link_lost, 1'b0);
    chk("idle_blank", bus.blank, 1'b0);
    chk("idle_score", bus.score, 16'h0);
    chk("idle_de", de_cnt, 0);
    n = 100;
    while (!bus.link_lost && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    chk("lost_rise", bus.link_lost, 1'b1);
    chk("lost_delay", n >= TO && n <= TO + 2, 1'b1);
    frame(16'h0427, 0);
    chk("lost_clear", bus.link_lost, 1'b0);
    exp_q.push_back(16'h0427);
    for (int i = 0; i < 3; i++) digit(sel_lut[i], lut[(i == 0) ? 7 : (i == 1) ? 2 : 4]);
    put(4'b1110, 8'hC0);
    @(negedge clk);
    chk("lat_e1", bus.score_valid, 1'b0);
    @(negedge clk);
    chk("lat_e2", bus.score_valid, 1'b0);
    @(negedge clk);
    chk("lat_e3_sv", bus.score_valid, 1'b1);
    chk("lat_e3_score", bus.score, 16'h0427);
    @(negedge clk);
    chk("sv_one_cycle", bus.score_valid, 1'b0);
    frame(16'h0427, 0);
    chk("third_scan_score", bus.score, 16'h0427);
    frame(16'h0427, 0);
    frame(16'h0427, 1);
    chk("decode_err_once", de_cnt, 1);
    frame(16'h0427, 0);
    frame(16'h0427, 0);
    chk("err_recover_score", bus.score, 16'h0427);
    frame(16'h0427, 0);
    frame(16'h0427, 0);
    frame(16'h0428, 0);
    chk("no_pulse_scan3", bus.score, 16'h0427);
    exp_q.push_back(16'h0428);
    frame(16'h0428, 0);
    chk("scan4_score", bus.score, 16'h0428);
    put(4'b0111, 8'hF8);
    n = 0;
    while (!bus.link_lost && n < 3 * TO) begin
      @(negedge clk);
      n++;
    end
    chk("stall_ll", bus.link_lost, 1'b1);
    chk("stall_score", bus.score, 16'h0428);
    digit(4'b1011, 8'hA4);
    chk("resume_ll", bus.link_lost, 1'b0);
    digit(4'b1101, 8'h99);
    digit(4'b1110, 8'hC0);
    digit(4'b0111, 8'hF8);
    digit(4'b1011, 8'hA4);
    put(4'b0000, 8'h00);
    @(negedge clk);
    chk("blank_set", bus.blank, 1'b1);
    chk("blank_score", bus.score, 16'h0428);
    repeat (5) @(negedge clk);
    frame(16'h0000, 0);
    chk("blank_one_frame", bus.score, 16'h0428);
    exp_q.push_back(16'h0000);
    frame(16'h0000, 0);
    chk("blank_republish", bus.score, 16'h0000);
    chk("blank_clear", bus.blank, 1'b0);
    frame(16'h0427, 0);
    exp_q.push_back(16'h0427);
    frame(16'h0427, 0);
    chk("pre_rst_score", bus.score, 16'h0427);
    digit(4'b0111, 8'hF8);
    digit(4'b1011, 8'hA4);
    rst = 1'b0;
    #1;
    chk("mid_rst_score", bus.score, 16'h0);
    chk("mid_rst_sv", bus.score_valid, 1'b0);
    chk("mid_rst_de", bus.decode_err, 1'b0);
    chk("mid_rst_ll", bus.link_lost, 1'b0);
    chk("mid_rst_blank", bus.blank, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    frame(16'h0427, 0);
    repeat (10) @(negedge clk);
    chk("post_rst_no_pub", bus.score, 16'h0);
    chk("queue_drained", exp_q.size(), 0);
    chk("de_total", de_cnt, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/seg_scan_decoder.md
# seg_scan_decoder

Receiver for the multiplexed 4-digit seven-segment score bus driven by the score display block. It watches the active-low segment byte and active-low digit select, maps each scanned pattern back to a BCD digit, and assembles complete 4-digit frames. A score is published only after two consecutive identical frames, giving a glitch-free 16-bit BCD score for the game-over/VGA path without rerouting the internal score register. It also flags undecodable patterns, a stalled scan, and the restart blanking state.

## Interface
- `TIMEOUT_CYC`, default 400_000: clocks without a new digit before the link is declared lost (two full scan periods).
- `clk` input 1: system clock. All inputs are synchronous to it.
- `rst` input 1: reset, asynchronous, active-low.
- `seg_in` input 8: segment byte, active-low, bit7 = dp (1 = off).
- `sel_in` input 4: digit select, active-low one-hot.
  - 0111 = units, 1011 = tens, 1101 = hundreds, 1110 = thousands.
  - 0000 = restart blank.
- `score` output 16: published BCD score, thousands in [15:12].
- `score_valid` output 1: one-cycle pulse when `score` changes.
- `decode_err` output 1: one-cycle pulse on an unmappable segment byte.
- `link_lost` output 1: level, scan stalled.
- `blank` output 1: level, `sel_q` == 0000.

## Operation
- Stage 1 registers the inputs: `seg_q`, `sel_q` and the previous value `sel_p`.
  - Reset values: `sel_q` = `sel_p` = 1111, `seg_q` = FF.
- Capture event: `sel_q` != `sel_p` and `sel_q` is one of the four valid codes.
- Decode map, exact byte match, any other byte is invalid:
  - C0=0, F9=1, A4=2, B0=3, 99=4
  - 92=5, 82=6, F8=7, 80=8, 90=9
- Valid capture: write the digit into the slot chosen by `sel_q` and set that slot's `mask` bit.
  - Recapturing an already-set slot overwrites it. This is not an error.
- Invalid capture: pulse `decode_err`, clear `mask`, clear `cand_vld`. No slot is written.
- Frame complete when `mask` == 1111. On the next cycle:
  - If `cand_vld` and the assembled value == `cand` and != `score`: load `score` and pulse `score_valid`.
  - In all cases: `cand` <= assembled, `cand_vld` <= 1, `mask` <= 0.
- Restart: while `sel_q` == 0000, `blank` = 1, `mask`/`cand_vld` are held cleared, and the timeout counter is held at 0.
  - `score` holds its value. The next two clean frames republish the score; after a restart that is 0000.
- Watchdog: a counter clears on each capture event and while blanked, and saturates at `TIMEOUT_CYC`.
  - At `TIMEOUT_CYC`: `link_lost` <= 1, `mask` and `cand_vld` are cleared.
  - `link_lost` clears on the next capture event.
  - `score` is held throughout.
- States:
  - IDLE: `cand_vld` = 0.
  - ARMED: `cand_vld` = 1.
  - LOST: `link_lost` = 1.
  - BLANK: `sel_q` == 0000. BLANK takes priority over every other transition.

## Timing
- Reset values:
  - `score` = 0000
  - `score_valid` = 0, `decode_err` = 0
  - `link_lost` = 0, `blank` = 0
  - `mask` = 0, `cand` = 0, `cand_vld` = 0, timeout counter = 0
- Edge E1 samples the last digit's new `sel_in`. The slot and `mask` update at E2. `score`/`score_valid` update at E3.
  - Latency is 3 clocks from the sampling edge.
- `decode_err` is asserted the cycle after E1, i.e. at E2.
- `blank` follows `sel_q`, one clock after `sel_in`.
- An invalid capture and frame completion cannot coincide: an invalid capture never sets `mask`.
- `score_valid` never fires twice for the same value. It never fires from a single frame.
- Asserting `rst` mid-frame returns every register to its reset value immediately. Nothing is published until two full frames arrive after release.

## Test plan
- Reset, then idle inputs (`sel_in` = 1111) for 100 clocks:
  - all outputs stay 0.
  - `link_lost` rises after `TIMEOUT_CYC` clocks.
- Two scans of 0427 (units 7=F8, tens 2=A4, hundreds 4=99, thousands 0=C0):
  - `score` = 16'h0427 and `score_valid` pulses once, 3 clocks after the 8th digit.
  - A third identical scan produces no pulse.
- Scans 0427, 0427, 0428, 0428:
  - pulse to 0427 after scan 2, pulse to 0428 after scan 4.
  - No pulse after scan 3.
- Valid 0427 frame, then a frame with tens byte = FF:
  - `decode_err` pulses once.
  - The next single clean 0427 frame gives no pulse; a second one gives no pulse because `score` is unchanged.
- Hold `sel_in` = 0111 constant for `TIMEOUT_CYC` clocks:
  - `link_lost` = 1 and `score` is held.
  - Resume scanning: `link_lost` clears on the first capture event.
- Mid-frame `sel_in`/`seg_in` = 0000/00:
  - `blank` = 1 one clock later.
  - Then two scans of 0000: `score` = 0000 with one `score_valid` pulse.
- Assert `rst` mid-frame: all outputs return to reset values.
